fc_bus_slave: RTL and testbench

Bus responder at the far end of the FC unit's initiator interface. It accepts single-outstanding write and read bursts on the AW/W/AR/R channels and services them from a local word-addressed register-array memory that holds weights and partial sums. Two user-bit modes are supported. aw ap=1 makes a write accumulate into the stored word. ar ap=1 clears each word after it is read, for partial-sum drain.

---
 rtl/fc_bus_pkg.sv | 7 +
 rtl/fc_mem_array.sv | 28 ++
 rtl/fc_bus_slave.sv | 133 +++++++++++++
 tb/tb_fc_bus_slave.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_bus_pkg.sv
// fc_bus_pkg: shared types and widths for the FC bus responder.
package fc_bus_pkg;
   localparam int LEN_W = 4;
   localparam int ID_W  = 4;
   typedef enum logic [1:0] {IDLE, WDATA, RDATA} state_t;
   typedef enum logic {GRANT_W, GRANT_R} grant_t;
endpackage

// File: rtl/fc_mem_array.sv
// fc_mem_array: word register array with byte-enable write, accumulate and clear ports.
module fc_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int PW     = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                we_i,
   input  logic                acc_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic [PW-1:0]       waddr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic                clr_i,
   input  logic [PW-1:0]       caddr_i,
   input  logic [PW-1:0]       raddr_i,
   output logic [DATA_W-1:0]   rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   // clear is last so it wins over a write to the same word
   always_ff @(posedge clk) begin
      if (we_i)
         for (int b = 0; b < DATA_W/8; b++)
            if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      if (acc_i) mem_q[waddr_i] <= mem_q[waddr_i] + wdata_i;
      if (clr_i) mem_q[caddr_i] <= '0;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fc_bus_slave.sv
// fc_bus_slave: single-outstanding burst responder over a local accumulate/clear-capable memory.
module fc_bus_slave
   import fc_bus_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 28
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [LEN_W-1:0]    awlen,
   input  logic [ID_W-1:0]     awuser_id,
   input  logic                awuser_ap,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic [ID_W-1:0]     wuser_id,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [LEN_W-1:0]    arlen,
   input  logic [ID_W-1:0]     aruser_id,
   input  logic                aruser_ap,
   output logic                rvalid,
   input  logic                rready,
   output logic [DATA_W-1:0]   rdata,
   output logic                rlast,
   output logic [ID_W-1:0]     rid,
   output logic                wr_done,
   output logic                err
);
   localparam int PW = $clog2(DEPTH);
   state_t state_q, state_d;
   grant_t pref_q, pref_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [ID_W-1:0] id_q, id_d;
   logic ap_q, ap_d, wr_done_q, wr_done_d, err_q, err_d;
   logic w_beat, r_beat, id_ok;
   logic [DATA_W-1:0] mem_rdata;
   logic unused_addr;
   assign unused_addr = ^{awaddr[ADDR_W-1:PW], araddr[ADDR_W-1:PW]};
   assign awready = rst_n && state_q == IDLE && awvalid && (!arvalid || pref_q == GRANT_W);
   assign arready = rst_n && state_q == IDLE && arvalid && (!awvalid || pref_q == GRANT_R);
   assign wready  = state_q == WDATA;
   assign rvalid  = state_q == RDATA;
   assign rdata   = rvalid ? mem_rdata : '0;
   assign rid     = rvalid ? id_q : '0;
   assign rlast   = rvalid && cnt_q == '0;
   assign wr_done = wr_done_q;
   assign err     = err_q;
   assign w_beat  = wready && wvalid;
   assign r_beat  = rvalid && rready;
   assign id_ok   = wuser_id == id_q;
   fc_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PW(PW)) u_mem (
      .clk     (clk),
      .we_i    (w_beat && id_ok && !ap_q),
      .acc_i   (w_beat && id_ok && ap_q),
      .be_i    (wstrb),
      .waddr_i (ptr_q),
      .wdata_i (wdata),
      .clr_i   (r_beat && ap_q),
      .caddr_i (ptr_q),
      .raddr_i (ptr_q),
      .rdata_o (mem_rdata)
   );
   always_comb begin
      state_d   = state_q;
      pref_d    = pref_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      id_d      = id_q;
      ap_d      = ap_q;
      wr_done_d = 1'b0;
      err_d     = 1'b0;
      if (awready) begin
         state_d = WDATA;
         pref_d  = GRANT_R;
         ptr_d   = awaddr[PW-1:0];
         cnt_d   = awlen;
         id_d    = awuser_id;
         ap_d    = awuser_ap;
      end else if (arready) begin
         state_d = RDATA;
         pref_d  = GRANT_W;
         ptr_d   = araddr[PW-1:0];
         cnt_d   = arlen;
         id_d    = aruser_id;
         ap_d    = aruser_ap;
      end
      // a burst ends on the counted last beat or an early wlast, whichever comes first
      if (w_beat) begin
         ptr_d = ptr_q + PW'(1);
         cnt_d = cnt_q - LEN_W'(1);
         err_d = !id_ok || (wlast != (cnt_q == '0));
         if (wlast || cnt_q == '0) begin
            state_d   = IDLE;
            wr_done_d = 1'b1;
         end
      end
      if (r_beat) begin
         ptr_d   = ptr_q + PW'(1);
         cnt_d   = cnt_q - LEN_W'(1);
         state_d = cnt_q == '0 ? IDLE : RDATA;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pref_q    <= GRANT_W;
         ptr_q     <= '0;
         cnt_q     <= '0;
         id_q      <= '0;
         ap_q      <= 1'b0;
         wr_done_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pref_q    <= pref_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
         ap_q      <= ap_d;
         wr_done_q <= wr_done_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: tb/tb_fc_bus_slave.sv
// tb_fc_bus_slave: table vectors, directed corner sequences and random bursts against a word-array model.
module tb_fc_bus_slave;
   localparam int DW = 32, DEPTH = 256, AW = 28;
   logic clk, rst_n;
   logic awvalid, awready, awuser_ap, wvalid, wready, wlast, arvalid, arready, aruser_ap;
   logic rvalid, rready, rlast, wr_done, err;
   logic [AW-1:0] awaddr, araddr;
   logic [3:0] awlen, awuser_id, wuser_id, arlen, aruser_id, rid, wstrb;
   logic [DW-1:0] wdata, rdata;
   int total = 0, bad = 0;
   logic [DW-1:0] m [DEPTH];
   logic [DW-1:0] wd [16];
   logic [3:0] ws [16];
   logic rpat [16];

   fc_bus_slave #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .awuser_id(awuser_id), .awuser_ap(awuser_ap),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wuser_id(wuser_id),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .aruser_id(aruser_id), .aruser_ap(aruser_ap),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rid(rid),
      .wr_done(wr_done), .err(err)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic void chk(string n, logic [DW-1:0] a, logic [DW-1:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, a, e);
      end
   endfunction

   task automatic wr_burst(input logic [AW-1:0] a, input int len, input logic [3:0] id,
                           input logic ap, input int bad_b, input int last_b, input bit bubbles);
      logic [7:0] p;
      logic lst;
      int t;
      p = a[7:0];
      awvalid = 1; awaddr = a; awlen = len[3:0]; awuser_id = id; awuser_ap = ap;
      t = 0;
      #1;
      while (!awready && t < 20) begin @(negedge clk); #1; t++; end
      chk("aw_handshake", awready, 1);
      if (!awready) begin awvalid = 0; return; end
      @(negedge clk);
      awvalid = 0;
      for (int b = 0; b <= len; b++) begin
         if (bubbles && $urandom_range(3) == 0) begin
            wvalid = 0;
            @(negedge clk);
            chk("w_bubble_quiet", {wr_done, err}, 0);
         end
         lst = (b == last_b);
         wvalid = 1; wdata = wd[b]; wstrb = ws[b]; wlast = lst;
         wuser_id = (b == bad_b) ? id ^ 4'h1 : id;
         #1 chk("wready", wready, 1);
         if (b != bad_b) begin
            if (ap) m[p] = m[p] + wd[b];
            else for (int k = 0; k < 4; k++) if (ws[b][k]) m[p][8*k +: 8] = wd[b][8*k +: 8];
         end
         @(negedge clk);
         chk("w_err", err, (b == bad_b) || (lst != (b == len)));
         chk("wr_done", wr_done, lst || b == len);
         p++;
         if (lst || b == len) break;
      end
      wvalid = 0; wlast = 0;
      @(negedge clk);
      chk("w_pulse_end", {wr_done, err}, 0);
      chk("w_back_idle", wready, 0);
   endtask

   // mode: 0 always ready, 1 random, 2 from rpat; abort_b asserts reset before that beat
   task automatic rd_burst(input logic [AW-1:0] a, input int len, input logic [3:0] id,
                           input logic ap, input int mode, input int abort_b,
                           output logic [DW-1:0] first);
      logic [7:0] p;
      logic rr;
      int t, b, k;
      p = a[7:0];
      first = '0;
      arvalid = 1; araddr = a; arlen = len[3:0]; aruser_id = id; aruser_ap = ap;
      t = 0;
      #1;
      while (!arready && t < 20) begin @(negedge clk); #1; t++; end
      chk("ar_handshake", arready, 1);
      if (!arready) begin arvalid = 0; return; end
      @(negedge clk);
      arvalid = 0;
      b = 0; k = 0;
      while (b <= len && k < 100) begin
         if (b == abort_b) begin
            rst_n = 0;
            #1;
            chk("abort_rvalid", rvalid, 0);
            chk("abort_rdata", rdata, 0);
            chk("abort_rid_rlast", {rid, rlast}, 0);
            rready = 0;
            return;
         end
         chk("rvalid", rvalid, 1);
         chk("rdata", rdata, m[p]);
         chk("rid", rid, id);
         chk("rlast", rlast, b == len);
         if (k == 0) first = rdata;
         rr = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(1)) : rpat[k];
         rready = rr;
         @(negedge clk);
         if (rr) begin
            if (ap) m[p] = '0;
            p++;
            b++;
         end
         k++;
      end
      rready = 0;
      chk("r_done_idle", rvalid, 0);
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] prior;
      logic [DW-1:0] data;
      logic [3:0]    strb;
      logic          ap;
      logic [DW-1:0] exp;
   } vec_t;

   initial begin
      vec_t vt [7];
      logic [DW-1:0] got;
      int len, bb, lb;
      vt[0] = '{28'h20, 32'd100, 32'hFFFFFFFF, 4'hF, 1'b1, 32'd99};
      vt[1] = '{28'h21, 32'd100, 32'hFFFFFFFF, 4'h0, 1'b1, 32'd99};
      vt[2] = '{28'h22, 32'h11223344, 32'hAABBCCDD, 4'h0, 1'b0, 32'h11223344};
      vt[3] = '{28'h23, 32'h11223344, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h11BB33DD};
      vt[4] = '{28'h24, 32'h11223344, 32'hAABBCCDD, 4'b1010, 1'b0, 32'hAA22CC44};
      vt[5] = '{28'h25, 32'd5, 32'd7, 4'hF, 1'b1, 32'd12};
      vt[6] = '{28'hABC0026, 32'h80000000, 32'h80000000, 4'h0, 1'b1, 32'h0};
      rst_n = 0;
      awvalid = 1; arvalid = 1; wvalid = 0; rready = 0; wlast = 0;
      awaddr = '0; araddr = '0; awlen = 0; arlen = 0; awuser_id = 0; aruser_id = 0;
      awuser_ap = 0; aruser_ap = 0; wdata = 0; wstrb = 0; wuser_id = 0;
      #12;
      chk("rst_ready", {awready, arready, wready}, 0);
      chk("rst_rvalid_rlast", {rvalid, rlast}, 0);
      chk("rst_pulses", {wr_done, err}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rid", rid, 0);
      awvalid = 0; arvalid = 0;
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end
      for (int i = 0; i < 16; i++) wr_burst(AW'(i * 16), 15, 4'h0, 1'b0, -1, 15, 1'b0);

      foreach (vt[i]) begin
         wd[0] = vt[i].prior; ws[0] = 4'hF;
         wr_burst(vt[i].addr, 0, 4'h1, 1'b0, -1, 0, 1'b0);
         wd[0] = vt[i].data; ws[0] = vt[i].strb;
         wr_burst(vt[i].addr, 0, 4'h2, vt[i].ap, -1, 0, 1'b0);
         rd_burst(vt[i].addr, 0, 4'h3, 1'b0, 0, -1, got);
         chk("table_word", got, vt[i].exp);
      end

      for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); ws[i] = 4'hF; end
      wr_burst(28'h10, 3, 4'h5, 1'b0, -1, 3, 1'b0);
      rpat[0] = 1; rpat[1] = 0; rpat[2] = 1; rpat[3] = 1; rpat[4] = 1;
      rd_burst(28'h10, 3, 4'h9, 1'b1, 2, -1, got);
      chk("drain_first", got, 1);
      for (int i = 0; i < 4; i++) begin
         rd_burst(AW'(28'h10 + i), 0, 4'h1, 1'b0, 0, -1, got);
         chk("drain_cleared", got, 0);
      end

      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + DW'(i); ws[i] = 4'hF; end
      wr_burst(AW'(DEPTH - 2), 3, 4'h6, 1'b0, -1, 3, 1'b0);
      rd_burst(28'h0, 0, 4'h6, 1'b0, 0, -1, got);
      chk("wrap_addr0", got, 32'hA2);
      rd_burst(AW'(DEPTH - 2), 3, 4'h6, 1'b0, 1, -1, got);

      for (int i = 0; i < 4; i++) begin wd[i] = 32'h5000 + DW'(i); ws[i] = 4'hF; end
      wr_burst(28'h40, 3, 4'h7, 1'b0, -1, 3, 1'b0);
      for (int i = 0; i < 4; i++) wd[i] = 32'h6000 + DW'(i);
      wr_burst(28'h40, 3, 4'h7, 1'b0, 1, 3, 1'b0);
      rd_burst(28'h41, 0, 4'h7, 1'b0, 0, -1, got);
      chk("mismatch_kept", got, 32'h5001);
      for (int i = 0; i < 4; i++) wd[i] = 32'h7000 + DW'(i);
      wr_burst(28'h48, 3, 4'h8, 1'b0, -1, 1, 1'b0);
      rd_burst(28'h48, 3, 4'h8, 1'b0, 0, -1, got);
      wr_burst(28'h4C, 2, 4'h8, 1'b0, -1, 3, 1'b0);

      rd_burst(28'h40, 3, 4'h2, 1'b0, 0, 2, got);
      @(negedge clk);
      chk("abort_hold", {rvalid, awready, arready}, 0);
      rst_n = 1;
      @(negedge clk);

      awvalid = 1; awaddr = 28'h50; awlen = 0; awuser_id = 2; awuser_ap = 0;
      arvalid = 1; araddr = 28'h50; arlen = 0; aruser_id = 3; aruser_ap = 0;
      #1;
      chk("arb_first_write", {awready, arready}, 2'b10);
      @(negedge clk);
      chk("arb_busy", {awready, arready}, 0);
      wvalid = 1; wdata = 32'hCAFE0001; wstrb = 4'hF; wuser_id = 2; wlast = 1;
      m[8'h50] = 32'hCAFE0001;
      @(negedge clk);
      wvalid = 0; wlast = 0;
      #1;
      chk("arb_then_read", {awready, arready}, 2'b01);
      @(negedge clk);
      awvalid = 0; arvalid = 0;
      chk("arb_rdata", rdata, 32'hCAFE0001);
      chk("arb_rid_rlast", {rid, rlast, rvalid}, {4'h3, 2'b11});
      rready = 1;
      @(negedge clk);
      rready = 0;
      chk("arb_read_done", rvalid, 0);

      for (int it = 0; it < 40; it++) begin
         len = $urandom_range(15);
         if ($urandom_range(1) == 1) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            bb = $urandom_range(9) == 0 ? $urandom_range(len) : -1;
            lb = $urandom_range(9) == 0 ? $urandom_range(len) : len;
            wr_burst(AW'($urandom), len, 4'($urandom), 1'($urandom), bb, lb, 1'b1);
         end else
            rd_burst(AW'($urandom), len, 4'($urandom), 1'($urandom), 1, -1, got);
      end
      for (int i = 0; i < 16; i++) rd_burst(AW'(i * 16), 15, 4'hC, 1'b0, 0, -1, got);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
